conv_layer_input_fetch: RTL

Upstream feeder for the convolution input row cache. On command from the layer controller it reads image rows from a synchronous pixel ROM and streams them as pixel/read_index beats. Preload fills the three cache rows; each load fetches the next image row. Completion is reported on the controller's ack bus.

---
 rtl/conv_layer_input_fetch.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_input_fetch.sv
// conv_layer_input_fetch: streams image rows from a synchronous pixel ROM into
// the convolution row cache as pixel/read_index beats.
//   Issue stage : one ROM address per cycle (rom_addr/rom_en registered).
//   Beat stage  : ROM data registered into pixel_out two cycles after issue.
// Optional build macro CONV_FETCH_ZERO_PAD_EN: a load after the last image row
// emits a zero row (read_index 0..7, pixel_out 0, no ROM access) before ack.
module conv_layer_input_fetch #(
  parameter int WIDTH        = 32,
  parameter int IMAGE_SIZE   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int ROM_DEPTH    = 64,
  parameter int PRELOAD_ROWS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cmd,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  output logic [WIDTH-1:0]      pixel_out,
  output logic [4:0]            read_index,
  output logic [1:0]            preload_cycle,
  output logic [1:0]            ack,
  output logic                  busy,
  output logic                  image_done
);

  localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int RW = $clog2(IMAGE_SIZE + 1);

  localparam logic [1:0] CMD_PRELOAD_START = 2'd1;
  localparam logic [1:0] CMD_LOAD_START    = 2'd3;
  localparam logic [1:0] ACK_IDLE          = 2'd0;
  localparam logic [1:0] ACK_PRELOAD_FIN   = 2'd1;
  localparam logic [1:0] ACK_LOAD_FIN      = 2'd3;
  localparam logic [4:0] IDX_SHIFT         = 5'd8;
  localparam logic [4:0] IDX_IDLE          = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_LOAD, S_DRAIN, S_ACK} state_t;

  state_t                  state_q;
  logic [RW-1:0]           next_row_q;
  logic [CW-1:0]           col_q;
  logic                    shift_q;      // shift beat owed before next row
  logic                    pad_q;        // current load is a zero-pad row
  logic                    mode_load_q;  // 1: load, 0: preload
  logic [ADDR_WIDTH-1:0]   rom_addr_q;
  logic                    rom_en_q;
  logic                    busy_q;
  logic [1:0]              ack_q;
  logic [1:0]              pc_q;
  logic                    image_done_q;

  // beat pipeline: issue stage -> ROM stage -> output stage
  logic                    iss_vld_q, iss_last_q, iss_pad_q;
  logic [4:0]              iss_idx_q;
  logic                    s1_vld_q, s1_last_q, s1_pad_q;
  logic [4:0]              s1_idx_q;
  logic                    out_last_q;
  logic [4:0]              read_index_q;
  logic [WIDTH-1:0]        pixel_out_q;

  logic [ADDR_WIDTH-1:0]   issue_addr;
  int                      addr_full;

  // Row-major address of the current pixel, clamped to the ROM range
  always_comb begin
    addr_full = int'(next_row_q) * IMAGE_SIZE + int'(col_q);
    if (addr_full > ROM_DEPTH - 1) addr_full = ROM_DEPTH - 1;
    issue_addr = ADDR_WIDTH'(addr_full);
  end

  // Control FSM plus address issue stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      next_row_q   <= '0;
      col_q        <= '0;
      shift_q      <= 1'b0;
      pad_q        <= 1'b0;
      mode_load_q  <= 1'b0;
      rom_addr_q   <= '0;
      rom_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= ACK_IDLE;
      pc_q         <= 2'd0;
      image_done_q <= 1'b0;
      iss_vld_q    <= 1'b0;
      iss_last_q   <= 1'b0;
      iss_pad_q    <= 1'b0;
      iss_idx_q    <= IDX_IDLE;
    end else begin
      rom_en_q   <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_last_q <= 1'b0;
      iss_pad_q  <= 1'b0;
      // preload_cycle steps once each shift beat has been presented
      if (read_index_q == IDX_SHIFT) pc_q <= pc_q + 2'd1;
      case (state_q)
        S_IDLE: begin
          if (cmd == CMD_PRELOAD_START) begin
            next_row_q   <= '0;
            pc_q         <= 2'd0;
            image_done_q <= 1'b0;
            col_q        <= '0;
            shift_q      <= 1'b0;
            pad_q        <= 1'b0;
            mode_load_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_PRELOAD;
          end else if (cmd == CMD_LOAD_START) begin
            col_q       <= '0;
            shift_q     <= 1'b0;
            mode_load_q <= 1'b1;
            busy_q      <= 1'b1;
            if (next_row_q == RW'(IMAGE_SIZE)) begin
              image_done_q <= 1'b1;
`ifdef CONV_FETCH_ZERO_PAD_EN
              pad_q   <= 1'b1;
              state_q <= S_LOAD;
`else
              ack_q   <= ACK_LOAD_FIN;
              state_q <= S_ACK;
`endif
            end else begin
              pad_q   <= 1'b0;
              state_q <= S_LOAD;
            end
          end
        end
        S_PRELOAD, S_LOAD: begin
          iss_vld_q <= 1'b1;
          if (shift_q) begin
            iss_idx_q <= IDX_SHIFT;
            shift_q   <= 1'b0;
          end else begin
            iss_idx_q <= 5'(col_q);
            iss_pad_q <= pad_q;
            rom_en_q  <= !pad_q;
            if (!pad_q) rom_addr_q <= issue_addr;
            col_q <= col_q + CW'(1);
            if (col_q == CW'(IMAGE_SIZE - 1)) begin
              col_q <= '0;
              if (!pad_q) next_row_q <= next_row_q + RW'(1);
              if (state_q == S_PRELOAD && next_row_q != RW'(PRELOAD_ROWS - 1)) begin
                shift_q <= 1'b1;
              end else begin
                iss_last_q <= 1'b1;
                state_q    <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (out_last_q) begin
            ack_q   <= mode_load_q ? ACK_LOAD_FIN : ACK_PRELOAD_FIN;
            if (!mode_load_q) pc_q <= 2'd3;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          ack_q   <= ACK_IDLE;
          busy_q  <= 1'b0;
          pad_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Beat stage: align index with ROM data and register the pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_pad_q     <= 1'b0;
      s1_idx_q     <= IDX_IDLE;
      out_last_q   <= 1'b0;
      read_index_q <= IDX_IDLE;
      pixel_out_q  <= '0;
    end else begin
      s1_vld_q   <= iss_vld_q;
      s1_last_q  <= iss_last_q;
      s1_pad_q   <= iss_pad_q;
      s1_idx_q   <= iss_idx_q;
      out_last_q <= s1_vld_q & s1_last_q;
      if (s1_vld_q) begin
        read_index_q <= s1_idx_q;
        if (s1_idx_q != IDX_SHIFT) pixel_out_q <= s1_pad_q ? '0 : rom_data;
      end else begin
        read_index_q <= IDX_IDLE;
      end
    end
  end

  assign rom_addr      = rom_addr_q;
  assign rom_en        = rom_en_q;
  assign pixel_out     = pixel_out_q;
  assign read_index    = read_index_q;
  assign preload_cycle = pc_q;
  assign ack           = ack_q;
  assign busy          = busy_q;
  assign image_done    = image_done_q;

endmodule
